// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit for the RV32I core.
// Accepts one load/store from EX/MEM, runs a req/gnt/rvalid data-bus
// transaction, and returns an aligned, extended load result.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   in_valid / in_ready      upstream handshake (in_ready high only when idle)
//   in_is_load, in_is_store  op kind (both high is illegal)
//   in_funct3, in_addr       width/sign field and effective byte address
//   in_wdata                 store data (rs2)
//   dmem_req/we/addr/be/wdata  data-bus request side (registered)
//   dmem_gnt/rvalid/rdata      data-bus response side
//   out_valid                one-cycle completion pulse
//   out_err                  00 ok, 01 misaligned, 10 timeout, 11 illegal op
//   load_data                aligned, extended load result (0 for stores/errors)
module lsu_mem_stage #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_is_load,
  input  logic        in_is_store,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        out_valid,
  output logic [1:0]  out_err,
  output logic [31:0] load_data
);

  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT);
  localparam bit               TO_EN    = (TIMEOUT != 0);

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_TOUT  = 2'b10;
  localparam logic [1:0] ERR_ILL   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       addr_lo_q, addr_lo_d;
  logic [2:0]       funct3_q, funct3_d;
  logic             is_load_q, is_load_d;

  logic        dmem_req_d, dmem_we_d;
  logic [31:0] dmem_addr_d, dmem_wdata_d;
  logic [3:0]  dmem_be_d;
  logic        out_valid_d;
  logic [1:0]  out_err_d;
  logic [31:0] load_data_d;

  logic             accept;
  logic             illegal;
  logic             misaligned;
  logic [3:0]       st_be;
  logic [31:0]      st_wdata;
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout_hit;

  assign in_ready = (state_q == S_IDLE);
  assign accept   = in_valid && (state_q == S_IDLE) && (in_is_load || in_is_store);

  // Op legality and natural-alignment checks on the incoming op.
  assign illegal = (in_is_load && in_is_store)
                || (in_is_load && ((in_funct3 == 3'b011) || (in_funct3[2:1] == 2'b11)))
                || (in_is_store && (in_funct3 > 3'b010));
  assign misaligned = ((in_funct3[1:0] == 2'b01) && in_addr[0])
                   || ((in_funct3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00));

  // Budget counts every cycle in REQ/RESP; once the budget is spent it
  // stays spent, so a late gnt still leaves RESP bounded.
  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign timeout_hit = TO_EN && (cnt_inc >= TO_LIMIT);

  // Store byte-lane enables and lane-replicated data.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = in_wdata;
    case (in_funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << in_addr[1:0];
        st_wdata = {4{in_wdata[7:0]}};
      end
      2'b01: begin
        st_be    = in_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{in_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Select the addressed byte/halfword of the returned word and extend it.
  function automatic logic [31:0] extract(input logic [31:0] w,
                                          input logic [1:0]  lo,
                                          input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'd0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_lo_d    = addr_lo_q;
    funct3_d     = funct3_q;
    is_load_d    = is_load_q;
    dmem_req_d   = dmem_req;
    dmem_we_d    = dmem_we;
    dmem_addr_d  = dmem_addr;
    dmem_be_d    = dmem_be;
    dmem_wdata_d = dmem_wdata;
    out_valid_d  = 1'b0;
    out_err_d    = out_err;
    load_data_d  = load_data;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d       = '0;
          addr_lo_d   = in_addr[1:0];
          funct3_d    = in_funct3;
          is_load_d   = in_is_load;
          load_data_d = '0;
          if (illegal) begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            out_err_d   = ERR_ILL;
          end else if (misaligned) begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            out_err_d   = ERR_ALIGN;
          end else begin
            state_d      = S_REQ;
            out_err_d    = ERR_OK;
            dmem_req_d   = 1'b1;
            dmem_we_d    = in_is_store;
            dmem_addr_d  = {in_addr[31:2], 2'b00};
            dmem_be_d    = in_is_store ? st_be : 4'b1111;
            dmem_wdata_d = in_is_store ? st_wdata : 32'd0;
          end
        end
      end

      S_REQ: begin
        cnt_d = cnt_inc;
        if (dmem_gnt) begin
          dmem_req_d = 1'b0;
          if (is_load_q) begin
            state_d = S_RESP;
          end else begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            out_err_d   = ERR_OK;
          end
        end else if (timeout_hit) begin
          dmem_req_d  = 1'b0;
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          out_err_d   = ERR_TOUT;
          load_data_d = '0;
        end
      end

      S_RESP: begin
        cnt_d = cnt_inc;
        if (dmem_rvalid) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          out_err_d   = ERR_OK;
          load_data_d = extract(dmem_rdata, addr_lo_q, funct3_q);
        end else if (timeout_hit) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          out_err_d   = ERR_TOUT;
          load_data_d = '0;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_lo_q  <= '0;
      funct3_q   <= '0;
      is_load_q  <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      out_valid  <= 1'b0;
      out_err    <= '0;
      load_data  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_lo_q  <= addr_lo_d;
      funct3_q   <= funct3_d;
      is_load_q  <= is_load_d;
      dmem_req   <= dmem_req_d;
      dmem_we    <= dmem_we_d;
      dmem_addr  <= dmem_addr_d;
      dmem_be    <= dmem_be_d;
      dmem_wdata <= dmem_wdata_d;
      out_valid  <= out_valid_d;
      out_err    <= out_err_d;
      load_data  <= load_data_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Randomized + directed bench for lsu_mem_stage against a behavioural model.
// A second instance with a short bus-timeout budget covers the timeout path.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_is_load, in_is_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;

  logic        in_ready, dmem_req, dmem_we, out_valid;
  logic [31:0] dmem_addr, dmem_wdata, load_data;
  logic [3:0]  dmem_be;
  logic [1:0]  out_err;

  logic        to_in_ready, to_req, to_we, to_out_valid;
  logic [31:0] to_addr, to_wdata, to_load_data;
  logic [3:0]  to_be;
  logic [1:0]  to_err;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  lsu_mem_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_is_load(in_is_load), .in_is_store(in_is_store), .in_funct3(in_funct3),
    .in_addr(in_addr), .in_wdata(in_wdata), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .out_valid(out_valid), .out_err(out_err), .load_data(load_data)
  );

  lsu_mem_stage #(.TIMEOUT(4), .CNT_W(5)) dut_to (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(to_in_ready),
    .in_is_load(in_is_load), .in_is_store(in_is_store), .in_funct3(in_funct3),
    .in_addr(in_addr), .in_wdata(in_wdata), .dmem_req(to_req), .dmem_we(to_we),
    .dmem_addr(to_addr), .dmem_be(to_be), .dmem_wdata(to_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .out_valid(to_out_valid), .out_err(to_err), .load_data(to_load_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Reference model: outcome of an op computed directly from the ISA rules.
  function automatic logic [1:0] mdl_err(input bit ld, input bit st, input int f3,
                                         input logic [31:0] addr);
    int sz;
    if (ld && st) return 2'd3;
    if (ld && (f3 == 3 || f3 == 6 || f3 == 7)) return 2'd3;
    if (st && f3 > 2) return 2'd3;
    sz = f3 % 4;
    if (sz == 1 && (addr % 2) != 0) return 2'd1;
    if (sz == 2 && (addr % 4) != 0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [3:0] mdl_be(input bit ld, input int f3, input logic [31:0] addr);
    if (ld) return 4'hF;
    if (f3 == 0) return 4'(1 << (addr % 4));
    if (f3 == 1) return ((addr % 4) >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] mdl_wd(input bit ld, input int f3, input logic [31:0] wd);
    if (ld) return 32'd0;
    if (f3 == 0) return (wd % 256) * 32'h0101_0101;
    if (f3 == 1) return (wd % 65536) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] mdl_ld(input int f3, input logic [31:0] addr,
                                         input logic [31:0] rd);
    logic [31:0] v;
    int n;
    n = int'(addr % 4);
    if (f3 == 0 || f3 == 4) begin
      v = (rd >> (8 * n)) % 256;
      if (f3 == 0 && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (f3 == 1 || f3 == 5) begin
      v = (rd >> (16 * (n / 2))) % 65536;
      if (f3 == 1 && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // Drives one op from an idle cycle through completion; gd = cycles before gnt,
  // rvd = cycles from gnt to rvalid (>=1). Entered and left #1 after a clock edge.
  task automatic run_op(input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input int gd, input int rvd,
                        output logic [31:0] ld_got);
    logic [1:0]  e_err;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_ld;
    int n;
    e_err = mdl_err(ld, st, int'(f3), addr);
    e_be  = mdl_be(ld, int'(f3), addr);
    e_wd  = mdl_wd(ld, int'(f3), wd);
    e_ld  = (ld && e_err == 2'd0) ? mdl_ld(int'(f3), addr, rd) : 32'd0;

    chk("idle_ready", 32'(in_ready), 32'd1);
    in_valid    = 1'b1;
    in_is_load  = ld;
    in_is_store = st;
    in_funct3   = f3;
    in_addr     = addr;
    in_wdata    = wd;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'($urandom_range(0, 1));
    dmem_rdata  = $urandom;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;

    if (e_err != 2'd0) begin
      n = 0;
      while (!out_valid && n < 3) begin
        chk("err_no_req", 32'(dmem_req), 32'd0);
        @(posedge clk); #1;
        n++;
      end
      chk("err_no_req", 32'(dmem_req), 32'd0);
      chk("err_done", 32'(out_valid), 32'd1);
    end else begin
      for (int i = 0; i <= gd; i++) begin
        chk("req_hi", 32'(dmem_req), 32'd1);
        chk("req_addr", dmem_addr, addr & 32'hFFFF_FFFC);
        chk("req_be", 32'(dmem_be), 32'(e_be));
        chk("req_we", 32'(dmem_we), 32'(st));
        chk("req_wdata", dmem_wdata, e_wd);
        chk("busy_ready", 32'(in_ready), 32'd0);
        chk("req_no_done", 32'(out_valid), 32'd0);
        dmem_gnt = (i == gd);
        if (i == gd && ld) begin
          dmem_rvalid = 1'($urandom_range(0, 1));
          dmem_rdata  = ~rd;
        end
        @(posedge clk); #1;
      end
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      if (ld) begin
        for (int j = 1; j <= rvd; j++) begin
          chk("resp_req_lo", 32'(dmem_req), 32'd0);
          chk("resp_no_done", 32'(out_valid), 32'd0);
          chk("resp_ready", 32'(in_ready), 32'd0);
          if (j == rvd) begin
            dmem_rvalid = 1'b1;
            dmem_rdata  = rd;
          end
          @(posedge clk); #1;
        end
        dmem_rvalid = 1'b0;
      end
      chk("done", 32'(out_valid), 32'd1);
    end
    chk("done_err", 32'(out_err), 32'(e_err));
    chk("done_ldata", load_data, e_ld);
    chk("done_ready", 32'(in_ready), 32'd0);
    ld_got      = load_data;
    in_valid    = 1'b0;
    in_is_load  = 1'b0;
    in_is_store = 1'b0;
    @(posedge clk); #1;
    chk("post_done", 32'(out_valid), 32'd0);
    chk("post_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    bit ld, st;
    logic [2:0] f3;
    logic [31:0] addr;
    logic [31:0] pre;

    in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
    in_funct3 = '0; in_addr = '0; in_wdata = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_we", 32'(dmem_we), 32'd0);
    chk("rst_be", 32'(dmem_be), 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_ovalid", 32'(out_valid), 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);
    chk("rst_ldata", load_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Store byte: immediate gnt, completion two cycles after accept.
    run_op(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'd0, 0, 1, got);

    // Load extraction/extension from a known word.
    pre = 32'h80FF_7F01;
    run_op(1'b1, 1'b0, 3'b000, 32'h0000_2002, 32'd0, pre, 0, 1, got);
    chk("lb_val", got, 32'hFFFF_FFFF);
    run_op(1'b1, 1'b0, 3'b100, 32'h0000_2003, 32'd0, pre, 1, 1, got);
    chk("lbu_val", got, 32'h0000_0080);
    run_op(1'b1, 1'b0, 3'b001, 32'h0000_2000, 32'd0, pre, 0, 2, got);
    chk("lh_val", got, 32'h0000_7F01);
    run_op(1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'd0, pre, 2, 1, got);
    chk("lhu_val", got, 32'h0000_80FF);
    run_op(1'b1, 1'b0, 3'b010, 32'h0000_2000, 32'd0, pre, 0, 1, got);
    chk("lw_val", got, 32'h80FF_7F01);

    // Bus waits: gnt after 3 idle cycles, rvalid 2 cycles after gnt.
    run_op(1'b1, 1'b0, 3'b010, 32'h0000_2004, 32'd0, 32'h1234_5678, 3, 2, got);
    chk("wait_lw_val", got, 32'h1234_5678);

    // Misaligned and illegal ops.
    run_op(1'b1, 1'b0, 3'b010, 32'h0000_3002, 32'd0, 32'd0, 0, 1, got);
    run_op(1'b1, 1'b0, 3'b011, 32'h0000_3000, 32'd0, 32'd0, 0, 1, got);
    run_op(1'b0, 1'b1, 3'b001, 32'h0000_3001, 32'h1234, 32'd0, 0, 1, got);
    run_op(1'b1, 1'b1, 3'b010, 32'h0000_3000, 32'd0, 32'd0, 0, 1, got);

    // Valid op with neither flag set passes through untouched.
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("nop_no_done", 32'(out_valid), 32'd0);
    chk("nop_ready", 32'(in_ready), 32'd1);
    chk("nop_no_req", 32'(dmem_req), 32'd0);

    // Randomized ops, biased toward legal and aligned.
    for (int k = 0; k < 60; k++) begin
      ld = 1'($urandom_range(0, 1));
      st = !ld;
      if ($urandom_range(0, 15) == 0) begin ld = 1'b1; st = 1'b1; end
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        if (ld) begin
          case ($urandom_range(0, 4))
            0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100;
            default: f3 = 3'b101;
          endcase
        end else begin
          f3 = 3'($urandom_range(0, 2));
        end
      end
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'b01) addr[0] = 1'b0;
        if (f3[1:0] == 2'b10) addr[1:0] = 2'b00;
      end
      run_op(ld, st, f3, addr, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(1, 3), got);
    end

    // Timeout on the short-budget instance: gnt never comes.
    do_reset();
    in_valid = 1'b1; in_is_load = 1'b1; in_is_store = 1'b0;
    in_funct3 = 3'b010; in_addr = 32'h0000_4000;
    @(posedge clk); #1;
    for (int i = 1; i <= 4; i++) begin
      chk("to_req_hi", 32'(to_req), 32'd1);
      chk("to_addr", to_addr, 32'h0000_4000);
      chk("to_be", 32'(to_be), 32'hF);
      chk("to_we", 32'(to_we), 32'd0);
      chk("to_wdata", to_wdata, 32'd0);
      chk("to_no_done", 32'(to_out_valid), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_is_load = 1'b0;
    chk("to_req_lo", 32'(to_req), 32'd0);
    chk("to_done", 32'(to_out_valid), 32'd1);
    chk("to_err", 32'(to_err), 32'd2);
    chk("to_ldata", to_load_data, 32'd0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    chk("to_post_done", 32'(to_out_valid), 32'd0);
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    chk("to_stray_rvalid", 32'(to_out_valid), 32'd0);
    chk("to_ready", 32'(to_in_ready), 32'd1);
    chk("to_ldata_kept", to_load_data, 32'd0);

    // Reset while waiting for rvalid; a late rvalid must be ignored.
    do_reset();
    in_valid = 1'b1; in_is_load = 1'b1; in_is_store = 1'b0;
    in_funct3 = 3'b010; in_addr = 32'h0000_5000;
    @(posedge clk); #1;
    in_valid = 1'b0; in_is_load = 1'b0;
    chk("mr_req", 32'(dmem_req), 32'd1);
    dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    chk("mr_resp_req", 32'(dmem_req), 32'd0);
    chk("mr_resp_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mr_ready", 32'(in_ready), 32'd1);
    chk("mr_req_lo", 32'(dmem_req), 32'd0);
    chk("mr_no_done", 32'(out_valid), 32'd0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    chk("mr_late_rvalid", 32'(out_valid), 32'd0);
    chk("mr_ldata", load_data, 32'd0);
    chk("mr_ready2", 32'(in_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
